// File: rtl/generador_pixeles.sv
// Pixel generator for an 8x8 board placed downstream of the VGA timing
// controller. Buttons move a cursor and toggle per-cell marks once per
// frame; the RGB pipeline is two stages deep and the syncs/blank are
// re-timed by the same two registers so everything leaves aligned.
module generador_pixeles #(
  parameter int GRID_N    = 8,
  parameter int CELL_LOG2 = 5,
  parameter int ORIGIN_X  = 192,
  parameter int ORIGIN_Y  = 112,
  parameter int V_ACTIVE  = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] cuenta_x,
  input  logic [9:0] cuenta_y,
  input  logic       blank_in,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       btn_arriba,
  input  logic       btn_abajo,
  input  logic       btn_izq,
  input  logic       btn_der,
  input  logic       btn_sel,
  output logic [7:0] rojo,
  output logic [7:0] verde,
  output logic [7:0] azul,
  output logic       blank_out,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic [2:0] cursor_fila,
  output logic [2:0] cursor_col,
  output logic [6:0] conteo_marcadas
);

  localparam int IDX_W  = $clog2(GRID_N);
  localparam int IDX2_W = 2 * IDX_W;
  localparam int N_CELL = 1 << IDX2_W;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(GRID_N - 1);
  localparam logic signed [10:0] LADO = 11'(GRID_N << CELL_LOG2);
  localparam logic signed [10:0] OX   = 11'(ORIGIN_X);
  localparam logic signed [10:0] OY   = 11'(ORIGIN_Y);

  // Button order in the vectors below: 0 arriba, 1 abajo, 2 izq, 3 der, 4 sel
  logic [4:0] btn_vec;
  logic [4:0] sync1, sync2, prev, pend, rise;
  logic       tick;

  assign btn_vec = {btn_sel, btn_der, btn_izq, btn_abajo, btn_arriba};
  assign rise    = sync2 & ~prev;
  // Frame tick: first pixel of the first blanking line, once per frame
  assign tick    = (cuenta_x == 10'd0) && (cuenta_y == 10'(V_ACTIVE));

  // Synchronise buttons, detect rising edges and latch pending actions
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 5'b00000;
      sync2 <= 5'b00000;
      prev  <= 5'b00000;
      pend  <= 5'b00000;
    end else begin
      sync1 <= btn_vec;
      sync2 <= sync1;
      prev  <= sync2;
      // an edge seen in the tick cycle itself survives into the next frame
      pend  <= tick ? rise : (pend | rise);
    end
  end

  // Board state
  logic [IDX_W-1:0]  fila_q, col_q, fila_next, col_next;
  logic [N_CELL-1:0] marcas, marcas_next;
  logic [6:0]        conteo, conteo_next;
  logic [IDX2_W-1:0] sel_idx;

  // Apply pending moves then the select toggle at the post-move cursor
  always_comb begin
    fila_next   = fila_q;
    col_next    = col_q;
    marcas_next = marcas;
    conteo_next = conteo;
    sel_idx     = {fila_q, col_q};
    if (tick) begin
      if (pend[0] && !pend[1]) begin
        fila_next = (fila_q == {IDX_W{1'b0}}) ? IDX_MAX : fila_q - IDX_W'(1);
      end else if (pend[1] && !pend[0]) begin
        fila_next = (fila_q == IDX_MAX) ? {IDX_W{1'b0}} : fila_q + IDX_W'(1);
      end else begin
        fila_next = fila_q;
      end
      if (pend[2] && !pend[3]) begin
        col_next = (col_q == {IDX_W{1'b0}}) ? IDX_MAX : col_q - IDX_W'(1);
      end else if (pend[3] && !pend[2]) begin
        col_next = (col_q == IDX_MAX) ? {IDX_W{1'b0}} : col_q + IDX_W'(1);
      end else begin
        col_next = col_q;
      end
      sel_idx = {fila_next, col_next};
      if (pend[4]) begin
        marcas_next[sel_idx] = ~marcas[sel_idx];
        if (marcas[sel_idx]) begin
          conteo_next = conteo - 7'd1;
        end else begin
          conteo_next = conteo + 7'd1;
        end
      end else begin
        conteo_next = conteo;
      end
    end else begin
      sel_idx = {fila_q, col_q};
    end
  end

  // Board registers, only change on the frame tick
  always_ff @(posedge clk) begin
    if (rst) begin
      fila_q <= {IDX_W{1'b0}};
      col_q  <= {IDX_W{1'b0}};
      marcas <= {N_CELL{1'b0}};
      conteo <= 7'd0;
    end else begin
      fila_q <= fila_next;
      col_q  <= col_next;
      marcas <= marcas_next;
      conteo <= conteo_next;
    end
  end

  assign cursor_fila     = 3'(fila_q);
  assign cursor_col      = 3'(col_q);
  assign conteo_marcadas = conteo;

  // Stage 1 geometry: signed offsets so pixels left/above the board are negative
  logic signed [10:0] dx, dy;
  logic dx_in, dy_in, dx_cl, dy_cl, dentro_s, borde_s;

  assign dx       = signed'({1'b0, cuenta_x}) - OX;
  assign dy       = signed'({1'b0, cuenta_y}) - OY;
  assign dx_in    = (dx >= 11'sd0) && (dx < LADO);
  assign dy_in    = (dy >= 11'sd0) && (dy < LADO);
  assign dx_cl    = (dx >= 11'sd0) && (dx <= LADO);
  assign dy_cl    = (dy >= 11'sd0) && (dy <= LADO);
  assign dentro_s = dx_in && dy_in;
  // grid lines inside the board plus the closing right/bottom lines
  assign borde_s  = (dentro_s && ((dx[CELL_LOG2-1:0] == '0) || (dy[CELL_LOG2-1:0] == '0)))
                 || ((dx == LADO) && dy_cl) || ((dy == LADO) && dx_cl);

  logic             dentro_r, borde_r, blank_d, hs_d, vs_d;
  logic [IDX_W-1:0] fila_r, col_r;

  // Stage 1 registers: cell geometry plus first delay of blank/syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      dentro_r <= 1'b0;
      borde_r  <= 1'b0;
      fila_r   <= {IDX_W{1'b0}};
      col_r    <= {IDX_W{1'b0}};
      blank_d  <= 1'b0;
      hs_d     <= 1'b1;
      vs_d     <= 1'b1;
    end else begin
      dentro_r <= dentro_s;
      borde_r  <= borde_s;
      fila_r   <= dy[CELL_LOG2 +: IDX_W];
      col_r    <= dx[CELL_LOG2 +: IDX_W];
      blank_d  <= blank_in;
      hs_d     <= h_sync_in;
      vs_d     <= v_sync_in;
    end
  end

  logic [23:0] color_s;
  logic        es_cursor, marcado;

  assign es_cursor = (fila_r == fila_q) && (col_r == col_q);
  assign marcado   = marcas[{fila_r, col_r}];

  // Stage 2 colour selection by priority
  always_comb begin
    color_s = 24'h000000;
    if (!blank_d) begin
      color_s = 24'h000000;
    end else if (borde_r) begin
      color_s = 24'hFFFFFF;
    end else if (!dentro_r) begin
      color_s = 24'h000080;
    end else if (es_cursor && marcado) begin
      color_s = 24'hFF8000;
    end else if (es_cursor) begin
      color_s = 24'hFFFF00;
    end else if (marcado) begin
      color_s = 24'hFF0000;
    end else begin
      color_s = 24'h404040;
    end
  end

  // Stage 2 registers: colour out, second delay of blank/syncs
  always_ff @(posedge clk) begin
    if (rst) begin
      rojo       <= 8'h00;
      verde      <= 8'h00;
      azul       <= 8'h00;
      blank_out  <= 1'b0;
      h_sync_out <= 1'b1;
      v_sync_out <= 1'b1;
    end else begin
      rojo       <= color_s[23:16];
      verde      <= color_s[15:8];
      azul       <= color_s[7:0];
      blank_out  <= blank_d;
      h_sync_out <= hs_d;
      v_sync_out <= vs_d;
    end
  end

endmodule

// File: tb/tb_generador_pixeles.sv
// Directed bench for generador_pixeles: a table of pixel vectors plus
// hand-written button/tick sequences for cursor, marks and reset.
module tb_generador_pixeles;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] cuenta_x, cuenta_y;
  logic       blank_in, h_sync_in, v_sync_in;
  logic       btn_arriba, btn_abajo, btn_izq, btn_der, btn_sel;
  logic [7:0] rojo, verde, azul;
  logic       blank_out, h_sync_out, v_sync_out;
  logic [2:0] cursor_fila, cursor_col;
  logic [6:0] conteo_marcadas;

  int n_vec = 0;
  int n_err = 0;

  generador_pixeles dut (
    .clk(clk), .rst(rst), .cuenta_x(cuenta_x), .cuenta_y(cuenta_y),
    .blank_in(blank_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .btn_arriba(btn_arriba), .btn_abajo(btn_abajo), .btn_izq(btn_izq),
    .btn_der(btn_der), .btn_sel(btn_sel),
    .rojo(rojo), .verde(verde), .azul(azul), .blank_out(blank_out),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .cursor_fila(cursor_fila), .cursor_col(cursor_col),
    .conteo_marcadas(conteo_marcadas)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        bl;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tabla [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    cuenta_x = 10'd5; cuenta_y = 10'd500;
    blank_in = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_tick();
    cuenta_x = 10'd0; cuenta_y = 10'd480;
    @(negedge clk);
    idle();
  endtask

  // 0 arriba, 1 abajo, 2 izq, 3 der, 4 sel
  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_arriba = v;
      1: btn_abajo  = v;
      2: btn_izq    = v;
      3: btn_der    = v;
      default: btn_sel = v;
    endcase
  endtask

  task automatic pulse(input int b);
    set_btn(b, 1'b1);
    cycles(2);
    set_btn(b, 1'b0);
    cycles(3);
  endtask

  task automatic pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] exp);
    cuenta_x = x; cuenta_y = y; blank_in = 1'b1;
    cycles(2);
    check(name, {8'h00, rojo, verde, azul}, {8'h00, exp});
    idle();
  endtask

  task automatic check_cur(input string name, input logic [2:0] f, input logic [2:0] c,
                           input logic [6:0] n);
    check({name, "_fila"}, {29'd0, cursor_fila}, {29'd0, f});
    check({name, "_col"}, {29'd0, cursor_col}, {29'd0, c});
    check({name, "_conteo"}, {25'd0, conteo_marcadas}, {25'd0, n});
  endtask

  initial begin
    tabla[0]  = '{10'd192, 10'd112, 1'b1, 1'b0, 1'b1, 24'hFFFFFF};
    tabla[1]  = '{10'd200, 10'd120, 1'b1, 1'b1, 1'b0, 24'hFFFF00};
    tabla[2]  = '{10'd100, 10'd50,  1'b1, 1'b0, 1'b0, 24'h000080};
    tabla[3]  = '{10'd200, 10'd120, 1'b0, 1'b1, 1'b1, 24'h000000};
    tabla[4]  = '{10'd240, 10'd120, 1'b1, 1'b1, 1'b1, 24'h404040};
    tabla[5]  = '{10'd448, 10'd120, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    tabla[6]  = '{10'd449, 10'd120, 1'b1, 1'b1, 1'b1, 24'h000080};
    tabla[7]  = '{10'd200, 10'd367, 1'b1, 1'b1, 1'b1, 24'h404040};
    tabla[8]  = '{10'd200, 10'd368, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};
    tabla[9]  = '{10'd200, 10'd111, 1'b1, 1'b1, 1'b1, 24'h000080};
    tabla[10] = '{10'd224, 10'd120, 1'b1, 1'b1, 1'b1, 24'hFFFFFF};

    // Reset with buttons toggling and non-idle video inputs
    rst = 1'b1;
    cuenta_x = 10'd200; cuenta_y = 10'd120;
    blank_in = 1'b1; h_sync_in = 1'b0; v_sync_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      btn_arriba = i[0]; btn_abajo = ~i[0]; btn_izq = i[0];
      btn_der = ~i[0]; btn_sel = i[0];
      @(negedge clk);
    end
    check("rst_rgb", {8'h00, rojo, verde, azul}, 32'h0);
    check("rst_blank", {31'd0, blank_out}, 32'd0);
    check("rst_hs", {31'd0, h_sync_out}, 32'd1);
    check("rst_vs", {31'd0, v_sync_out}, 32'd1);
    check_cur("rst", 3'd0, 3'd0, 7'd0);
    btn_arriba = 1'b0; btn_abajo = 1'b0; btn_izq = 1'b0; btn_der = 1'b0; btn_sel = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b0;
    cycles(4);
    do_tick();
    check_cur("post_rst_tick", 3'd0, 3'd0, 7'd0);

    // Pixel table, cursor at (0,0), no marks
    for (int i = 0; i < 11; i++) begin
      cuenta_x = tabla[i].x; cuenta_y = tabla[i].y;
      blank_in = tabla[i].bl; h_sync_in = tabla[i].hs; v_sync_in = tabla[i].vs;
      cycles(2);
      check($sformatf("vec%0d_rgb", i), {8'h00, rojo, verde, azul}, {8'h00, tabla[i].rgb});
      check($sformatf("vec%0d_sync", i), {29'd0, blank_out, h_sync_out, v_sync_out},
            {29'd0, tabla[i].bl, tabla[i].hs, tabla[i].vs});
    end
    idle();

    // Wrap up/left from (0,0)
    pulse(0); pulse(2);
    do_tick();
    check_cur("wrap", 3'd7, 3'd7, 7'd0);
    // Three presses collapse to one step
    pulse(1); pulse(1); pulse(1);
    do_tick();
    check_cur("collapse", 3'd0, 3'd7, 7'd0);
    // Up+down cancel, right wraps col 7 -> 0
    pulse(0); pulse(1); pulse(3);
    do_tick();
    check_cur("simult", 3'd0, 3'd0, 7'd0);

    // Select at (0,0)
    pulse(4);
    do_tick();
    check_cur("sel1", 3'd0, 3'd0, 7'd1);
    pixel("sel1_pix", 10'd200, 10'd120, 24'hFF8000);
    pulse(3);
    do_tick();
    check_cur("move_r", 3'd0, 3'd1, 7'd1);
    pixel("marked_pix", 10'd200, 10'd120, 24'hFF0000);
    pixel("cursor_pix", 10'd240, 10'd120, 24'hFFFF00);
    // Move back left and unmark in the same frame
    pulse(2); pulse(4);
    do_tick();
    check_cur("unmark", 3'd0, 3'd0, 7'd0);
    pixel("unmark_pix", 10'd200, 10'd120, 24'hFFFF00);

    // Edge landing in the tick cycle stays pending; held level does not repeat
    btn_der = 1'b1;
    cycles(2);
    do_tick();
    check_cur("edge_in_tick", 3'd0, 3'd0, 7'd0);
    cycles(3);
    do_tick();
    check_cur("edge_next", 3'd0, 3'd1, 7'd0);
    cycles(3);
    do_tick();
    check_cur("held_norep", 3'd0, 3'd1, 7'd0);
    btn_der = 1'b0;
    cycles(3);

    // Reset mid-frame drops a pending select
    pulse(4);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    do_tick();
    check_cur("mid_rst", 3'd0, 3'd0, 7'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
